// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a common-anode 7-segment display with NUM_DIGITS
// digits. Each digit owns one slot of CLK_DIV system clocks. The first
// BLANK_CYCLES clocks of every slot keep all anodes off so the previous digit's
// segment pattern cannot ghost onto the next digit. Brightness is a 16-level
// PWM applied per whole frame (one frame = one full scan of all digits).
//
// Parameters
//   NUM_DIGITS   : number of multiplexed digits (>= 2, any value)
//   CLK_DIV      : clocks per digit slot (>= 2)
//   BLANK_CYCLES : dark clocks at the start of each slot (1 .. CLK_DIV-1)
//
// Ports
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset, released synchronously
//   digits_i     : packed hex nibbles, digit k = digits_i[4k+3:4k], 0 = rightmost
//   digit_en_i   : per-digit enable (0 = digit dark)
//   dp_i         : per-digit decimal point request (1 = lit)
//   lzb_en_i     : leading-zero blanking enable
//   brightness_i : PWM level, 0 = off, 15 = always on
//   anode_o      : active-low anode selects
//   segments_o   : active-low cathodes, bit0 = A .. bit6 = G
//   dp_o         : active-low decimal point
//   frame_o      : one-cycle pulse after the scan wraps from the last digit to 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 100
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   digit_en_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    lzb_en_i,
   input  logic [3:0]              brightness_i,
   output logic [NUM_DIGITS-1:0]   anode_o,
   output logic [6:0]              segments_o,
   output logic                    dp_o,
   output logic                    frame_o
);

   localparam int SLOT_W = $clog2(CLK_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_FIRST_LIT = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------------
   // Scan state
   // ---------------------------------------------------------------------
   logic [SLOT_W-1:0] slot_cnt_reg, slot_cnt_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [3:0]        frame_cnt_reg, frame_cnt_next;
   logic              frame_next;

   // Input snapshot, held constant for the whole slot
   logic [4*NUM_DIGITS-1:0] digits_snap_reg;
   logic [NUM_DIGITS-1:0]   en_snap_reg;
   logic [NUM_DIGITS-1:0]   dp_snap_reg;
   logic                    lzb_snap_reg;
   logic [3:0]              bright_snap_reg;
   logic                    snap_load;

   // Derived display data
   logic [3:0]            digit_val [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lzb_blank;
   logic                  bright_ok;
   logic                  lit;

   // Next values of the registered pins
   logic [NUM_DIGITS-1:0] anode_next;
   logic [6:0]            segments_next;
   logic                  dp_next;

   // ---------------------------------------------------------------------
   // Active-low hex glyphs, bit order {G,F,E,D,C,B,A}
   // ---------------------------------------------------------------------
   function automatic logic [6:0] hex7_n(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'h0:    pattern = 7'b1000000;
         4'h1:    pattern = 7'b1111001;
         4'h2:    pattern = 7'b0100100;
         4'h3:    pattern = 7'b0110000;
         4'h4:    pattern = 7'b0011001;
         4'h5:    pattern = 7'b0010010;
         4'h6:    pattern = 7'b0000010;
         4'h7:    pattern = 7'b1111000;
         4'h8:    pattern = 7'b0000000;
         4'h9:    pattern = 7'b0010000;
         4'hA:    pattern = 7'b0001000;
         4'hB:    pattern = 7'b0000011;
         4'hC:    pattern = 7'b1000110;
         4'hD:    pattern = 7'b0100001;
         4'hE:    pattern = 7'b0000110;
         default: pattern = 7'b0001110;
      endcase
      return pattern;
   endfunction

   // ---------------------------------------------------------------------
   // Slot prescaler, digit index and frame counter
   // ---------------------------------------------------------------------
   always_comb begin
      slot_cnt_next  = slot_cnt_reg + SLOT_W'(1);
      idx_next       = idx_reg;
      frame_cnt_next = frame_cnt_reg;
      frame_next     = 1'b0;
      if (slot_cnt_reg == SLOT_LAST) begin
         slot_cnt_next = '0;
         // Explicit wrap so a non-power-of-two digit count works
         if (idx_reg == IDX_LAST) begin
            idx_next       = '0;
            frame_cnt_next = frame_cnt_reg + 4'd1;
            frame_next     = 1'b1;
         end else begin
            idx_next = idx_reg + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_cnt_reg  <= '0;
         idx_reg       <= '0;
         frame_cnt_reg <= '0;
      end else begin
         slot_cnt_reg  <= slot_cnt_next;
         idx_reg       <= idx_next;
         frame_cnt_reg <= frame_cnt_next;
      end
   end

   // ---------------------------------------------------------------------
   // Snapshot: captured while slot_cnt is 0. That cycle is always inside the
   // blanking interval, so the stale snapshot used during it is never shown.
   // ---------------------------------------------------------------------
   assign snap_load = (slot_cnt_reg == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digits_snap_reg <= '0;
         en_snap_reg     <= '0;
         dp_snap_reg     <= '0;
         lzb_snap_reg    <= 1'b0;
         bright_snap_reg <= '0;
      end else if (snap_load) begin
         digits_snap_reg <= digits_i;
         en_snap_reg     <= digit_en_i;
         dp_snap_reg     <= dp_i;
         lzb_snap_reg    <= lzb_en_i;
         bright_snap_reg <= brightness_i;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
         assign digit_val[gi] = digits_snap_reg[4*gi +: 4];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Leading-zero blanking: walk from the most significant digit down,
   // blanking enabled zeros until the first enabled nonzero digit. Disabled
   // digits are skipped without ending the walk. Digit 0 always shows.
   // ---------------------------------------------------------------------
   always_comb begin
      logic leading;
      lzb_blank = '0;
      leading   = lzb_snap_reg;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (leading && en_snap_reg[k]) begin
            if (digit_val[k] == 4'h0) begin
               lzb_blank[k] = 1'b1;
            end else begin
               leading = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Lit decision and output pattern. Segments and DP are only driven when
   // an anode is on, so a dark cycle is fully dark on every pin.
   // ---------------------------------------------------------------------
   always_comb begin
      bright_ok = (bright_snap_reg == 4'hF) || (frame_cnt_reg < bright_snap_reg);
      lit       = (slot_cnt_reg >= SLOT_FIRST_LIT) &&
                  en_snap_reg[idx_reg] &&
                  !lzb_blank[idx_reg] &&
                  bright_ok;

      anode_next    = '1;
      segments_next = 7'h7F;
      dp_next       = 1'b1;
      if (lit) begin
         anode_next    = ~(NUM_DIGITS'(1) << idx_reg);
         segments_next = hex7_n(digit_val[idx_reg]);
         dp_next       = ~dp_snap_reg[idx_reg];
      end
   end

   // Registered pins; reset blanks them without waiting for a clock edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         anode_o    <= '1;
         segments_o <= 7'h7F;
         dp_o       <= 1'b1;
         frame_o    <= 1'b0;
      end else begin
         anode_o    <= anode_next;
         segments_o <= segments_next;
         dp_o       <= dp_next;
         frame_o    <= frame_next;
      end
   end

endmodule
